alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU between NUM_REQ requesters (e.g. fetch/address-calc, execute, debug port) using round-robin arbitration.
- Each requester uses a valid/ready request handshake. Results return through one registered response channel, tagged with the requester ID.
- Sits between the pipeline issue logic and the ALU instance. It drives the ALU's aluOp/srcA/srcB and captures its result.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/alu_arbiter.sv | 92 +++++++++
 tb/tb_alu_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared ALU opcodes, widths and arbiter state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 16;

  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;

  typedef logic [OP_W-1:0] alu_op_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin arbiter, search starts at ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Walk ptr, ptr+1, ... with wrap; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        w_sum = {1'b0, ptr} + (PW+1)'(k);
        if (w_sum >= (PW+1)'(N)) begin
          w_sum = w_sum - (PW+1)'(N);
        end
        w_idx = w_sum[PW-1:0];
        if (!w_found && req[w_idx]) begin
          w_found       = 1'b1;
          grant[w_idx]  = 1'b1;
          grant_idx     = w_idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one external ALU, 1-deep response slot
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_src_a,
  output logic [DATA_W-1:0]         alu_src_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result
);

  import alu_pkg::*;

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;

  logic                w_slot_free;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_xfer;

  assign w_slot_free = (r_state == EMPTY) | rsp_ready;
  assign w_xfer      = |w_grant;

  // Held off during reset so no request is accepted or reaches the ALU.
  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_ptr),
    .enable    (w_slot_free & ~rst),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign req_ready = w_grant;

  always_comb begin
    alu_op    = OP_W'(OP_NOP);
    alu_src_a = '0;
    alu_src_b = '0;
    if (w_xfer) begin
      alu_op    = req_op[w_grant_idx*OP_W +: OP_W];
      alu_src_a = req_a[w_grant_idx*DATA_W +: DATA_W];
      alu_src_b = req_b[w_grant_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_ptr        <= '0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else if (w_xfer) begin
      r_state      <= FULL;
      r_rsp_id     <= w_grant_idx;
      r_rsp_result <= alu_result;
      r_ptr        <= (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    end else if (rsp_ready) begin
      r_state <= EMPTY;
    end
  end

  assign rsp_valid  = (r_state == FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter : directed self-checking bench with a behavioural ADD-only ALU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_src_a;
  logic [15:0] alu_src_b;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Reference ALU: only ADD is implemented, everything else returns 0.
  assign alu_result = (alu_op == 4'b0001) ? alu_src_a + alu_src_b : 16'h0000;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[i*4 +: 4]   = op;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 16'(i + 1), 16'h0001);
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_req_ready got=%b exp=%b", req_ready, 4'b0000);
    end
    total++;
    if (alu_op !== 4'b0000) begin
      bad++;
      $display("FAIL reset_alu_op got=%h exp=%h", alu_op, 4'h0);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rsp got v=%b id=%0d r=%h exp v=0 id=0 r=0000", rsp_valid, rsp_id, rsp_result);
    end
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 4'b0001, 16'd3, 16'd4);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0001);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'd7) begin
      bad++;
      $display("FAIL single_rsp got v=%b id=%0d r=%h exp v=1 id=0 r=0007", rsp_valid, rsp_id, rsp_result);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got v=%b exp v=0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 16'(i), 16'd10);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_id = n % 4;
      #1;
      total++;
      if (req_ready !== 4'(1 << exp_id)) begin
        bad++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b", n, req_ready, 4'(1 << exp_id));
      end
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_result !== 16'(10 + exp_id)) begin
        bad++;
        $display("FAIL rr_rsp[%0d] got v=%b id=%0d r=%0d exp v=1 id=%0d r=%0d",
                 n, rsp_valid, rsp_id, rsp_result, exp_id, 10 + exp_id);
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 4'b0001, 16'd100, 16'd1);
    set_req(1, 4'b0001, 16'd200, 16'd1);
    set_req(2, 4'b0001, 16'd2,   16'd3);
    set_req(3, 4'b0001, 16'd20,  16'd1);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_first_grant got=%b exp=%b", req_ready, 4'b0100);
    end
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++;
      if (req_ready !== 4'b0000 || alu_op !== 4'b0000) begin
        bad++;
        $display("FAIL bp_stall[%0d] got ready=%b op=%h exp ready=0000 op=0", n, req_ready, alu_op);
      end
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 16'h0005) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b id=%0d r=%h exp v=1 id=2 r=0005", n, rsp_valid, rsp_id, rsp_result);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL bp_release_grant got=%b exp=%b", req_ready, 4'b1000);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 16'd21) begin
      bad++;
      $display("FAIL bp_release_rsp got v=%b id=%0d r=%0d exp v=1 id=3 r=21", rsp_valid, rsp_id, rsp_result);
    end
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL bp_b2b_grant got=%b exp=%b", req_ready, 4'b0001);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'd101) begin
      bad++;
      $display("FAIL bp_b2b_rsp got v=%b id=%0d r=%0d exp v=1 id=0 r=101", rsp_valid, rsp_id, rsp_result);
    end
    tick();
  endtask

  task automatic test_wrap_and_unsupported();
    do_reset();
    set_req(0, 4'b0001, 16'hFFFF, 16'h0002);
    set_req(1, 4'b0111, 16'h0005, 16'h0005);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    tick();
    req_valid = 4'b0010;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_add got v=%b id=%0d r=%h exp v=1 id=0 r=0001", rsp_valid, rsp_id, rsp_result);
    end
    #1;
    total++;
    if (req_ready !== 4'b0010 || alu_op !== 4'b0111) begin
      bad++;
      $display("FAIL unsup_drive got ready=%b op=%h exp ready=0010 op=7", req_ready, alu_op);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 16'h0000) begin
      bad++;
      $display("FAIL unsup_rsp got v=%b id=%0d r=%h exp v=1 id=1 r=0000", rsp_valid, rsp_id, rsp_result);
    end
    tick();
  endtask

  task automatic test_ptr_hold();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 16'(i + 50), 16'd7);
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL hold_grant3 got=%b exp=%b", req_ready, 4'b1000);
    end
    tick();
    req_valid = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      #1;
      total++;
      if (alu_op !== 4'h0 || alu_src_a !== 16'h0 || alu_src_b !== 16'h0 || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL idle_drive[%0d] got op=%h a=%h b=%h ready=%b exp all zero", n, alu_op, alu_src_a, alu_src_b, req_ready);
      end
      tick();
    end
    req_valid = 4'b1010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL hold_after_idle got=%b exp=%b", req_ready, 4'b0010);
    end
    tick();
    total++;
    if (rsp_id !== 2'd1 || rsp_result !== 16'd58) begin
      bad++;
      $display("FAIL hold_rsp got id=%0d r=%0d exp id=1 r=58", rsp_id, rsp_result);
    end
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL hold_next_grant got=%b exp=%b", req_ready, 4'b1000);
    end
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 4'b0001, 16'h0011, 16'h0000);
    set_req(1, 4'b0001, 16'h00AA, 16'h0000);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 16'h00AA) begin
      bad++;
      $display("FAIL mid_setup got v=%b id=%0d r=%h exp v=1 id=1 r=00aa", rsp_valid, rsp_id, rsp_result);
    end
    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL mid_ready_in_rst got=%b exp=%b", req_ready, 4'b0000);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 16'h0000) begin
      bad++;
      $display("FAIL mid_rsp_cleared got v=%b id=%0d r=%h exp v=0 id=0 r=0000", rsp_valid, rsp_id, rsp_result);
    end
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_ptr_zero got=%b exp=%b", req_ready, 4'b0001);
    end
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_and_unsupported();
    test_ptr_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
